// File: rtl/note_pkg.sv
// Shared types and constants for the note player.
// Half-period table is in 100 MHz cycles, octave 0 = C4..B4.
package note_pkg;

  localparam int HP_W   = 18;
  localparam int BEAT_W = 25;
  localparam int DUR_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    GAP
  } state_t;

  localparam logic [HP_W-1:0] HP [0:7] = '{
    18'd0,
    18'd191113,
    18'd170262,
    18'd151686,
    18'd143172,
    18'd127551,
    18'd113636,
    18'd101239
  };

endpackage

// File: rtl/beat_timer.sv
// Free-running beat counter with clear/enable.
// beat_tick is high in the last cycle of each beat.
module beat_timer
  import note_pkg::*;
#(
  parameter int BEAT_CYCLES = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic beat_tick
);

  localparam logic [BEAT_W-1:0] LAST =
    BEAT_W'(BEAT_CYCLES - 1);

  logic [BEAT_W-1:0] cnt;

  assign beat_tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= beat_tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/note_player.sv
// Square-wave note player with valid/ready note requests.
// Define NOTE_GAP_EN to insert a silent GAP after each note.
module note_player
  import note_pkg::*;
#(
  parameter int BEAT_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 2_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_note,
  input  logic [1:0] in_oct,
  input  logic [3:0] in_dur,
  input  logic       stop,
  output logic       bell,
  output logic       en,
  output logic       busy,
  output logic       done
);

  state_t state, state_d;

  logic [HP_W-1:0]  hp_q;
  logic [HP_W-1:0]  tone;
  logic [DUR_W:0]   beats;
  logic [1:0]       shift;
  logic             accept;
  logic             finish;
  logic             play;
  logic             beat_tick;
  logic             last_beat;

  assign play      = (state == PLAY);
  assign in_ready  = (state == IDLE) && !stop;
  assign busy      = (state != IDLE);
  assign last_beat = beat_tick && (beats == 1);
  assign shift     = (in_oct == 2'd3) ? 2'd2 : in_oct;

  beat_timer #(
    .BEAT_CYCLES(BEAT_CYCLES)
  ) u_beat (
    .clk      (clk),
    .rst      (rst),
    .clr      (!play),
    .en       (play),
    .beat_tick(beat_tick)
  );

`ifdef NOTE_GAP_EN
  logic [BEAT_W-1:0] gap_cnt;
  logic              gap_last;

  assign gap_last = (gap_cnt == BEAT_W'(GAP_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || state != GAP) begin
      gap_cnt <= '0;
    end else begin
      gap_cnt <= gap_cnt + 1'b1;
    end
  end
`else
  logic unused_gap;
  assign unused_gap = ^GAP_CYCLES;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    accept  = 1'b0;
    finish  = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          accept  = 1'b1;
          state_d = PLAY;
        end
      end
      PLAY: begin
        if (stop) begin
          state_d = IDLE;
        end else if (last_beat) begin
          finish = 1'b1;
`ifdef NOTE_GAP_EN
          state_d = GAP;
`else
          state_d = IDLE;
`endif
        end
      end
`ifdef NOTE_GAP_EN
      GAP: begin
        if (stop || gap_last) begin
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Tone phase restarts on every accept; bell is
  // forced low whenever PLAY is left.
  always_ff @(posedge clk) begin
    if (rst) begin
      hp_q  <= '0;
      beats <= '0;
      tone  <= '0;
      bell  <= 1'b0;
      en    <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= finish;
      if (accept) begin
        hp_q  <= HP[in_note] >> shift;
        beats <= (in_dur == '0) ?
                 (DUR_W+1)'(16) : {1'b0, in_dur};
        en    <= (in_note != 3'd0);
      end else begin
        if (state_d != PLAY) en <= 1'b0;
        if (play && beat_tick) beats <= beats - 1'b1;
      end
      if (accept || state_d != PLAY) begin
        tone <= '0;
        bell <= 1'b0;
      end else if (en) begin
        if (tone == hp_q - HP_W'(1)) begin
          tone <= '0;
          bell <= ~bell;
        end else begin
          tone <= tone + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_note_player.sv
// Scoreboard bench for note_player: expected toggle/done
// events are queued at accept time and matched by a monitor.
module tb_note_player;

  localparam int BEAT = 2000;
  localparam int GAPC = 5;
`ifdef NOTE_GAP_EN
  localparam int GAP_OFF = GAPC;
`else
  localparam int GAP_OFF = 0;
`endif

  typedef struct {
    bit kind;
    int cyc;
  } ev_t;

  typedef struct {
    logic [2:0] note;
    logic [1:0] oct;
    logic [3:0] dur;
    int hp;
    int len;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_note = '0;
  logic [1:0] in_oct = '0;
  logic [3:0] in_dur = '0;
  logic       stop = 1'b0;
  logic       bell, en, busy, done;

  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  ev_t q[$];
  logic bell_prev = 1'b0;

  vec_t vecs[4] = '{
    '{3'd7, 2'd2, 4'd15, 25309, 30000},
    '{3'd1, 2'd2, 4'd2,  47778, 4000},
    '{3'd5, 2'd3, 4'd0,  31887, 32000},
    '{3'd0, 2'd0, 4'd1,  0,     2000}
  };

  note_player #(
    .BEAT_CYCLES(BEAT),
    .GAP_CYCLES (GAPC)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_note (in_note),
    .in_oct  (in_oct),
    .in_dur  (in_dur),
    .stop    (stop),
    .bell    (bell),
    .en      (en),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic expect_ev(bit kind);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: kind=%0d cyc=%0d",
               kind, cyc);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.cyc != cyc) begin
        errors++;
        $display("FAIL event: got kind=%0d cyc=%0d want kind=%0d cyc=%0d",
                 kind, cyc, e.kind, e.cyc);
      end
    end
  endtask

  // kind 1 = done pulse, kind 0 = bell toggle
  always @(negedge clk) begin
    if (done) begin
      expect_ev(1'b1);
      chk("bell_low_at_done", int'(bell), 0);
    end else if (bell !== bell_prev) begin
      expect_ev(1'b0);
    end
    bell_prev = bell;
  end

  task automatic push(bit kind, int c);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    q.push_back(e);
  endtask

  task automatic send(input logic [2:0] n,
                      input logic [1:0] o,
                      input logic [3:0] d,
                      input int budget,
                      output int acc);
    bit got;
    got = 1'b0;
    acc = -1;
    @(negedge clk);
    in_note  = n;
    in_oct   = o;
    in_dur   = d;
    in_valid = 1'b1;
    for (int i = 0; i < budget; i++) begin
      #1;
      if (in_ready) begin
        acc = cyc + 1;
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (got) begin
      @(posedge clk);
      #1;
    end else begin
      chk("accept_timeout", 0, 1);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_within_budget", int'(ok), 1);
  endtask

  task automatic wait_cycles(int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc2;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_bell", int'(bell), 0);
    chk("rst_en", int'(en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ready", int'(in_ready), 1);

    foreach (vecs[v]) begin
      send(vecs[v].note, vecs[v].oct, vecs[v].dur,
           20, acc);
      if (vecs[v].hp > 0) begin
        for (int t = vecs[v].hp; t < vecs[v].len;
             t += vecs[v].hp) begin
          push(1'b0, acc + t);
        end
      end
      push(1'b1, acc + vecs[v].len);
      wait_cycles(3);
      chk("play_en", int'(en),
          int'(vecs[v].note != 3'd0));
      chk("play_busy", int'(busy), 1);
      chk("play_ready", int'(in_ready), 0);
      chk("play_bell", int'(bell), 0);
      wait_idle(vecs[v].len + GAP_OFF + 100);
      chk("pending_events", q.size(), 0);
      wait_cycles(2);
    end

    // stop during PLAY: no done, silent next edge
    send(3'd6, 2'd0, 4'd4, 20, acc);
    wait_cycles(50);
    stop = 1'b1;
    #1;
    chk("stop_ready_low", int'(in_ready), 0);
    @(negedge clk);
    #1;
    chk("stop_busy", int'(busy), 0);
    chk("stop_en", int'(en), 0);
    chk("stop_bell", int'(bell), 0);
    stop = 1'b0;
    #1;
    chk("stop_ready_back", int'(in_ready), 1);
    wait_cycles(10);

    // stop and in_valid together in IDLE
    @(negedge clk);
    stop     = 1'b1;
    in_valid = 1'b1;
    in_note  = 3'd1;
    in_dur   = 4'd1;
    #1;
    chk("stopvalid_ready", int'(in_ready), 0);
    @(negedge clk);
    #1;
    chk("stopvalid_busy", int'(busy), 0);
    in_valid = 1'b0;
    stop     = 1'b0;
    wait_cycles(2);

    // reset mid-note drops it without done
    send(3'd6, 2'd0, 4'd4, 20, acc);
    wait_cycles(50);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("midrst_bell", int'(bell), 0);
    chk("midrst_en", int'(en), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_ready", int'(in_ready), 1);
    rst = 1'b0;
    wait_cycles(5);

    // request held while busy, taken at first ready
    send(3'd1, 2'd2, 4'd1, 20, acc);
    push(1'b1, acc + BEAT);
    send(3'd0, 2'd0, 4'd1, BEAT + GAP_OFF + 100, acc2);
    chk("b2b_accept_cyc", acc2, acc + BEAT + 1 + GAP_OFF);
    push(1'b1, acc2 + BEAT);
    wait_idle(BEAT + GAP_OFF + 100);
    chk("b2b_pending", q.size(), 0);

    wait_cycles(5);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
